// File: rtl/exec_alu.sv
// Execute-stage ALU with HI/LO registers and a background 32-cycle signed divider.
// Define EXEC_DIV_EN to build the divider; otherwise div is a no-op and HI/LO stay 0.
module exec_alu (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [3:0]  alu_op,
   input  logic [1:0]  mf_sel,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [4:0]  shamt,
   output logic        stall,
   output logic        out_valid,
   output logic [31:0] result,
   output logic        illegal_op,
   output logic        div_busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   // Op encodings mirror the ALU_* defines of the decode stage.
   localparam logic [3:0] ALU_add     = 4'd1;
   localparam logic [3:0] ALU_sub     = 4'd2;
   localparam logic [3:0] ALU_OR      = 4'd3;
   localparam logic [3:0] ALU_sll     = 4'd4;
   localparam logic [3:0] ALU_sra     = 4'd5;
   localparam logic [3:0] ALU_slli    = 4'd6;
   localparam logic [3:0] ALU_div     = 4'd7;
   localparam logic [3:0] ALU_rs_pass = 4'd8;
   localparam logic [3:0] ALU_undef   = 4'd15;

   logic        need_hilo_s;
   logic        acc_s;
   logic [31:0] alu_res_s;

   assign need_hilo_s = (alu_op == ALU_div) || ((alu_op == ALU_rs_pass) && (mf_sel != 2'b00));
   assign stall       = in_valid && div_busy && need_hilo_s;
   assign acc_s       = in_valid && !stall;

   // Combinational result selection for the accepted op.
   always_comb begin
      alu_res_s = 32'h0000_0000;
      case (alu_op)
         ALU_add:  alu_res_s = op_a + op_b;
         ALU_sub:  alu_res_s = op_a - op_b;
         ALU_OR:   alu_res_s = op_a | op_b;
         ALU_sll:  alu_res_s = op_b << shamt;
         ALU_sra:  alu_res_s = 32'($signed(op_b) >>> shamt);
         ALU_slli: alu_res_s = {op_b[15:0], 16'h0000};
         ALU_rs_pass: begin
            case (mf_sel)
               2'b10:   alu_res_s = hi;
               2'b01:   alu_res_s = lo;
               default: alu_res_s = op_a;
            endcase
         end
         default:  alu_res_s = 32'h0000_0000;
      endcase
   end

   // Result register; a bubble holds the previous result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         result     <= 32'h0000_0000;
         illegal_op <= 1'b0;
      end else begin
         out_valid  <= acc_s;
         illegal_op <= acc_s && (alu_op == ALU_undef);
         if (acc_s) begin
            result <= alu_res_s;
         end else begin
            result <= result;
         end
      end
   end

`ifdef EXEC_DIV_EN
   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_ITER = 2'b01,
      DIV_FIX  = 2'b10
   } div_state_t;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   // |0x8000_0000| stays 0x8000_0000, which is correct as an unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? neg32(v) : v;
   endfunction

   div_state_t  state_r;
   logic [4:0]  cnt_r;
   logic        neg_q_r;
   logic        neg_r_r;
   logic        by_zero_r;
   logic [31:0] dividend_r;
   logic [31:0] quo_r;
   logic [31:0] rem_r;
   logic [31:0] den_r;
   logic [31:0] rem_shift_s;
   logic [32:0] diff_s;

   assign rem_shift_s = {rem_r[30:0], quo_r[31]};
   assign diff_s      = {1'b0, rem_shift_s} - {1'b0, den_r};

   // Divider FSM: capture magnitudes, 32 restoring steps, then sign fix-up into HI/LO.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= DIV_IDLE;
         cnt_r      <= 5'd0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         by_zero_r  <= 1'b0;
         dividend_r <= 32'h0000_0000;
         quo_r      <= 32'h0000_0000;
         rem_r      <= 32'h0000_0000;
         den_r      <= 32'h0000_0000;
         div_busy   <= 1'b0;
         hi         <= 32'h0000_0000;
         lo         <= 32'h0000_0000;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               if (acc_s && (alu_op == ALU_div)) begin
                  neg_q_r    <= op_a[31] ^ op_b[31];
                  neg_r_r    <= op_a[31];
                  by_zero_r  <= (op_b == 32'h0000_0000);
                  dividend_r <= op_a;
                  quo_r      <= abs32(op_a);
                  den_r      <= abs32(op_b);
                  rem_r      <= 32'h0000_0000;
                  cnt_r      <= 5'd0;
                  div_busy   <= 1'b1;
                  state_r    <= DIV_ITER;
               end else begin
                  state_r    <= DIV_IDLE;
               end
            end
            DIV_ITER: begin
               quo_r <= {quo_r[30:0], ~diff_s[32]};
               rem_r <= diff_s[32] ? rem_shift_s : diff_s[31:0];
               cnt_r <= cnt_r + 5'd1;
               if (cnt_r == 5'd31) begin
                  state_r <= DIV_FIX;
               end else begin
                  state_r <= DIV_ITER;
               end
            end
            DIV_FIX: begin
               if (by_zero_r) begin
                  lo <= 32'hFFFF_FFFF;
                  hi <= dividend_r;
               end else begin
                  lo <= neg_q_r ? neg32(quo_r) : quo_r;
                  hi <= neg_r_r ? neg32(rem_r) : rem_r;
               end
               div_busy <= 1'b0;
               state_r  <= DIV_IDLE;
            end
            default: begin
               div_busy <= 1'b0;
               state_r  <= DIV_IDLE;
            end
         endcase
      end
   end
`else
   assign div_busy = 1'b0;
   assign hi       = 32'h0000_0000;
   assign lo       = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_exec_alu.sv
// Randomized and directed bench for exec_alu against a cycle-level reference model.
module tb_exec_alu;

`ifdef EXEC_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_SRA  = 4'd5;
   localparam logic [3:0] OP_SLLI = 4'd6;
   localparam logic [3:0] OP_DIV  = 4'd7;
   localparam logic [3:0] OP_RSP  = 4'd8;
   localparam logic [3:0] OP_UND  = 4'd15;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [3:0]  alu_op;
   logic [1:0]  mf_sel;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  shamt;
   logic        stall;
   logic        out_valid;
   logic [31:0] result;
   logic        illegal_op;
   logic        div_busy;
   logic [31:0] hi;
   logic [31:0] lo;

   exec_alu dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .alu_op(alu_op), .mf_sel(mf_sel),
      .op_a(op_a), .op_b(op_b), .shamt(shamt), .stall(stall), .out_valid(out_valid),
      .result(result), .illegal_op(illegal_op), .div_busy(div_busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo, m_result;
   logic        m_valid, m_illegal;
   int          m_busy_left;
   logic        last_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [1:0] mf,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] sh);
      int sb;
      sb = b;
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_OR:   return a | b;
         OP_SLL:  return b * (32'd1 << sh);
         OP_SRA:  return sb >>> sh;
         OP_SLLI: return b * 32'h0001_0000;
         OP_RSP:  return (mf == 2'b10) ? m_hi : (mf == 2'b01) ? m_lo : a;
         default: return 32'h0000_0000;
      endcase
   endfunction

   task automatic ref_div(input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 32'h0000_0000) begin
         m_pend_lo = 32'hFFFF_FFFF;
         m_pend_hi = a;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         m_pend_lo = 32'h8000_0000;
         m_pend_hi = 32'h0000_0000;
      end else begin
         m_pend_lo = sa / sb;
         m_pend_hi = sa % sb;
      end
   endtask

   task automatic model_reset();
      m_hi = 32'h0; m_lo = 32'h0; m_result = 32'h0;
      m_valid = 1'b0; m_illegal = 1'b0; m_busy_left = 0;
   endtask

   task automatic check_outputs(input string sfx);
      check({"out_valid", sfx}, {31'h0, out_valid}, {31'h0, m_valid});
      check({"result", sfx}, result, m_result);
      check({"illegal_op", sfx}, {31'h0, illegal_op}, {31'h0, m_illegal});
      check({"div_busy", sfx}, {31'h0, div_busy}, {31'h0, (m_busy_left > 0)});
      check({"hi", sfx}, hi, m_hi);
      check({"lo", sfx}, lo, m_lo);
   endtask

   // One clock cycle: drive at negedge, check stall, advance model at posedge, check outputs.
   task automatic cycle(input logic v, input logic [3:0] op, input logic [1:0] mf,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      logic exp_stall, acc;
      logic [31:0] r;
      @(negedge clk);
      in_valid = v; alu_op = op; mf_sel = mf; op_a = a; op_b = b; shamt = sh;
      #1;
      exp_stall = v && (m_busy_left > 0) && (op == OP_DIV || (op == OP_RSP && mf != 2'b00));
      check("stall", {31'h0, stall}, {31'h0, exp_stall});
      last_stall = stall;
      acc = v && !exp_stall;
      r = ref_result(op, mf, a, b, sh);
      @(posedge clk);
      #1;
      if (m_busy_left > 0) begin
         m_busy_left--;
         if (m_busy_left == 0) begin
            m_hi = m_pend_hi;
            m_lo = m_pend_lo;
         end
      end
      if (acc && op == OP_DIV && DIV_EN) begin
         m_busy_left = 33;
         ref_div(a, b);
      end
      m_valid = acc;
      m_illegal = acc && (op == OP_UND);
      if (acc) m_result = r;
      check_outputs("");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 2'b00, $urandom, $urandom, 5'd0);
   endtask

   task automatic do_div(input logic [31:0] a, input logic [31:0] b);
      cycle(1'b1, OP_DIV, 2'b00, a, b, 5'd0);
      idle(33);
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [3:0] op_tab [12];
      int n;
      op_tab = '{OP_ADD, OP_SUB, OP_OR, OP_SLL, OP_SRA, OP_SLLI, OP_DIV, OP_RSP,
                 OP_RSP, OP_UND, 4'd0, 4'd11};
      reset = 1'b1; in_valid = 1'b0; alu_op = 4'd0; mf_sel = 2'b00;
      op_a = 32'h0; op_b = 32'h0; shamt = 5'd0; last_stall = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("_rst");
      @(negedge clk);
      reset = 1'b0;

      cycle(1'b1, OP_ADD, 2'b00, 32'h7FFF_FFFF, 32'h1, 5'd0);
      check("add_ovf", result, 32'h8000_0000);
      check("add_valid", {31'h0, out_valid}, 32'h1);
      cycle(1'b1, OP_SRA, 2'b00, 32'h0, 32'h8000_0000, 5'd4);
      check("sra", result, 32'hF800_0000);
      cycle(1'b1, OP_SLLI, 2'b00, 32'h0, 32'h0000_1234, 5'd0);
      check("slli", result, 32'h1234_0000);
      idle(1);
      check("bubble_hold", result, 32'h1234_0000);

      do_div(32'hFFFF_FFF9, 32'd2);
      idle(1);
      check("div_neg_lo", lo, DIV_EN ? 32'hFFFF_FFFD : 32'h0);
      check("div_neg_hi", hi, DIV_EN ? 32'hFFFF_FFFF : 32'h0);

      // dependent read: div in cycle 0, add in cycle 4, MFLO from cycle 5
      cycle(1'b1, OP_DIV, 2'b00, 32'd100, 32'd7, 5'd0);
      idle(3);
      cycle(1'b1, OP_ADD, 2'b00, 32'd3, 32'd4, 5'd0);
      check("add_in_div", result, 32'd7);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, OP_RSP, 2'b01, 32'hDEAD_BEEF, 32'h0, 5'd0);
         if (!last_stall) break;
         n++;
      end
      check("mflo_stalls", n, DIV_EN ? 32'd29 : 32'd0);
      check("mflo_res", result, DIV_EN ? 32'd14 : 32'd0);

      do_div(32'h0000_0055, 32'h0);
      check("div0_lo", lo, DIV_EN ? 32'hFFFF_FFFF : 32'h0);
      check("div0_hi", hi, DIV_EN ? 32'h0000_0055 : 32'h0);
      do_div(32'h8000_0000, 32'hFFFF_FFFF);
      check("ovf_lo", lo, DIV_EN ? 32'h8000_0000 : 32'h0);
      check("ovf_hi", hi, 32'h0);

      // reset asserted asynchronously in cycle 10 of a division
      do_div(32'd1000, 32'd3);
      cycle(1'b1, OP_DIV, 2'b00, 32'd77, 32'd5, 5'd0);
      idle(9);
      @(negedge clk);
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs("_midrst");
      @(negedge clk);
      reset = 1'b0;
      cycle(1'b1, OP_RSP, 2'b10, 32'h1111_1111, 32'h0, 5'd0);
      check("mfhi_after_rst", result, 32'h0);

      cycle(1'b1, OP_UND, 2'b00, 32'h5, 32'h6, 5'd0);
      check("undef_pulse", {31'h0, illegal_op}, 32'h1);
      idle(1);
      check("undef_clear", {31'h0, illegal_op}, 32'h0);

      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 9) < 8), op_tab[$urandom_range(0, 11)],
               2'($urandom_range(0, 3)), rnd_operand(), rnd_operand(), 5'($urandom));
      end
      idle(34);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
